score_keeper: RTL and testbench

//   Tracks frog row progress, current score, high score and level from game state and button ticks.

---
 rtl/score_keeper.sv | 201 ++++++++++++++++++++
 tb/tb_score_keeper.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/score_keeper.sv
// score_keeper
//   Tracks frog row progress, score, high score and level from the game state
//   and the button ticks. A shared double-dabble converter turns each value
//   into packed BCD digits for the UI text stage. Every value that changes has
//   a dirty flag. The converter serves these flags in priority order
//   score > hiscore > level.
//
// Build option: define SCORE_PENALTY_EN so that a down tick in PLAYING takes
//   ROW_POINTS off the score. The score saturates at 0.
//
// Ports
//   clk           in   system clock
//   reset         in   asynchronous, active-high reset
//   state[1:0]    in   game state: 0 MENU, 1 PLAYING, 2 DEAD, 3 WIN
//   btn_up_tick   in   one-cycle pulse, move up
//   btn_down_tick in   one-cycle pulse, move down
//   level_up      in   one-cycle pulse, frog reached the far side
//   score[9:0]    out  binary score
//   hiscore[9:0]  out  binary high score
//   level[6:0]    out  binary level
//   score_bcd     out  {hundreds,tens,ones} of score
//   hiscore_bcd   out  {hundreds,tens,ones} of hiscore
//   level_bcd     out  {tens,ones} of level
//   bcd_busy      out  converter is in SHIFT or DONE
//   conv_state    out  converter FSM state, exposed for debug
//
// Handshake: there is none. A *_bcd register is written in the single DONE
//   cycle. All of its digits are written together. bcd_busy falls on the
//   edge that performs the write.
module score_keeper #(
    parameter int MAX_ROW     = 14,
    parameter int ROW_POINTS  = 10,
    parameter int LEVEL_BONUS = 100,
    parameter int MAX_LEVEL   = 99,
    parameter int MAX_SCORE   = 999
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  state,
    input  logic        btn_up_tick,
    input  logic        btn_down_tick,
    input  logic        level_up,
    output logic [9:0]  score,
    output logic [9:0]  hiscore,
    output logic [6:0]  level,
    output logic [11:0] score_bcd,
    output logic [11:0] hiscore_bcd,
    output logic [7:0]  level_bcd,
    output logic        bcd_busy,
    output logic [1:0]  conv_state
);

    localparam logic [1:0] GS_MENU    = 2'd0;
    localparam logic [1:0] GS_PLAYING = 2'd1;

    localparam logic [1:0] C_IDLE  = 2'd0;
    localparam logic [1:0] C_SHIFT = 2'd1;
    localparam logic [1:0] C_DONE  = 2'd2;

    localparam logic [1:0] SEL_S = 2'd0;
    localparam logic [1:0] SEL_H = 2'd1;
    localparam logic [1:0] SEL_L = 2'd2;

    logic [3:0]  curr_y, max_y, curr_n, max_n;
    logic [9:0]  score_n, hiscore_n;
    logic [6:0]  level_n;
    logic        dirty_s, dirty_h, dirty_l;
    logic        clr_s, clr_h, clr_l;
    logic [1:0]  sel;
    logic [3:0]  cnt;
    logic [21:0] sh;   // {bcd[11:0], bin[9:0]}

    function automatic logic [9:0] sat_add(input logic [9:0] a, input int unsigned b);
        logic [10:0] sum;
        sum = {1'b0, a} + 11'(b);
        if (sum > 11'(MAX_SCORE)) return 10'(MAX_SCORE);
        return sum[9:0];
    endfunction

    // One double-dabble step: add 3 to each digit that is >= 5, then shift left.
    function automatic logic [21:0] dd_step(input logic [21:0] s);
        logic [21:0] t;
        t = s;
        for (int i = 0; i < 3; i++) begin
            if (t[10+4*i +: 4] >= 4'd5) t[10+4*i +: 4] = t[10+4*i +: 4] + 4'd3;
        end
        return {t[20:0], 1'b0};
    endfunction

    // Next-state logic for the game counters.
    always_comb begin
        curr_n  = curr_y;
        max_n   = max_y;
        score_n = score;
        level_n = level;
        if (state == GS_MENU) begin
            curr_n  = 4'd0;
            max_n   = 4'd0;
            score_n = 10'd0;
            level_n = 7'd1;
        end else if (level_up) begin
            // level_up takes priority over a tick in the same cycle.
            curr_n  = 4'd0;
            max_n   = 4'd0;
            level_n = (level >= 7'(MAX_LEVEL)) ? 7'(MAX_LEVEL) : level + 7'd1;
            score_n = sat_add(score, LEVEL_BONUS);
        end else if (state == GS_PLAYING && (btn_up_tick ^ btn_down_tick)) begin
            if (btn_up_tick) begin
                if (curr_y < 4'(MAX_ROW)) curr_n = curr_y + 4'd1;
                if (curr_n > max_y) begin
                    max_n   = curr_n;
                    score_n = sat_add(score, ROW_POINTS);
                end
            end else begin
                if (curr_y != 4'd0) curr_n = curr_y - 4'd1;
`ifdef SCORE_PENALTY_EN
                // maxY stays put, so climbing this row again awards no points.
                score_n = (score >= 10'(ROW_POINTS)) ? score - 10'(ROW_POINTS) : 10'd0;
`endif
            end
        end
    end

    // Compare against the registered score. The high score therefore lags by one cycle.
    assign hiscore_n = (score > hiscore) ? score : hiscore;

    // The flag cleared when IDLE picks a value. A change in the same cycle sets it again.
    assign clr_s = (conv_state == C_IDLE) && dirty_s;
    assign clr_h = (conv_state == C_IDLE) && !dirty_s && dirty_h;
    assign clr_l = (conv_state == C_IDLE) && !dirty_s && !dirty_h && dirty_l;

    assign bcd_busy = (conv_state != C_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            curr_y  <= 4'd0;
            max_y   <= 4'd0;
            score   <= 10'd0;
            hiscore <= 10'd0;
            level   <= 7'd1;
        end else begin
            curr_y  <= curr_n;
            max_y   <= max_n;
            score   <= score_n;
            hiscore <= hiscore_n;
            level   <= level_n;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dirty_s     <= 1'b0;
            dirty_h     <= 1'b0;
            dirty_l     <= 1'b0;
            conv_state  <= C_IDLE;
            sel         <= SEL_S;
            cnt         <= 4'd0;
            sh          <= 22'd0;
            score_bcd   <= 12'h000;
            hiscore_bcd <= 12'h000;
            level_bcd   <= 8'h01;
        end else begin
            dirty_s <= (score_n != score) | (dirty_s & ~clr_s);
            dirty_h <= (hiscore_n != hiscore) | (dirty_h & ~clr_h);
            dirty_l <= (level_n != level) | (dirty_l & ~clr_l);
            case (conv_state)
                C_IDLE: begin
                    cnt <= 4'd0;
                    if (dirty_s) begin
                        sel        <= SEL_S;
                        sh         <= {12'd0, score};
                        conv_state <= C_SHIFT;
                    end else if (dirty_h) begin
                        sel        <= SEL_H;
                        sh         <= {12'd0, hiscore};
                        conv_state <= C_SHIFT;
                    end else if (dirty_l) begin
                        sel        <= SEL_L;
                        sh         <= {12'd0, 3'd0, level};
                        conv_state <= C_SHIFT;
                    end
                end
                C_SHIFT: begin
                    sh  <= dd_step(sh);
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd9) conv_state <= C_DONE;
                end
                C_DONE: begin
                    case (sel)
                        SEL_S:   score_bcd   <= sh[21:10];
                        SEL_H:   hiscore_bcd <= sh[21:10];
                        default: level_bcd   <= sh[17:10];
                    endcase
                    conv_state <= C_IDLE;
                end
                default: conv_state <= C_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper. The stimulus pushes the expected BCD
// writes into exp_q. A monitor pops an entry each time the converter completes
// a conversion, and compares it.
module tb_score_keeper;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  state;
    logic        btn_up_tick, btn_down_tick, level_up;
    logic [9:0]  score, hiscore;
    logic [6:0]  level;
    logic [11:0] score_bcd, hiscore_bcd;
    logic [7:0]  level_bcd;
    logic        bcd_busy;
    logic [1:0]  conv_state;

    int          checks = 0;
    int          errors = 0;
    logic [13:0] exp_q[$];   // {kind[1:0], bcd[11:0]}; kind 0 score, 1 hiscore, 2 level
    bit          mon_en = 1'b0;
    logic        prev_busy = 1'b0;

    score_keeper dut (
        .clk           (clk),
        .reset         (reset),
        .state         (state),
        .btn_up_tick   (btn_up_tick),
        .btn_down_tick (btn_down_tick),
        .level_up      (level_up),
        .score         (score),
        .hiscore       (hiscore),
        .level         (level),
        .score_bcd     (score_bcd),
        .hiscore_bcd   (hiscore_bcd),
        .level_bcd     (level_bcd),
        .bcd_busy      (bcd_busy),
        .conv_state    (conv_state)
    );

    // clock
    always #5 clk = ~clk;

    // ---------------- scoreboard helpers ----------------
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic push(input logic [1:0] kind, input logic [11:0] val);
        exp_q.push_back({kind, val});
    endtask

    // Monitor: a falling bcd_busy marks one completed BCD write.
    always @(negedge clk) begin
        logic [13:0] e;
        logic [11:0] act;
        if (mon_en && !reset && prev_busy && !bcd_busy) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_bcd_write got write with empty queue expected none");
            end else begin
                e = exp_q.pop_front();
                case (e[13:12])
                    2'd0:    act = score_bcd;
                    2'd1:    act = hiscore_bcd;
                    default: act = {4'h0, level_bcd};
                endcase
                if (act != e[11:0]) begin
                    errors++;
                    $display("FAIL bcd_write_kind%0d got 0x%03h expected 0x%03h", e[13:12], act, e[11:0]);
                end
            end
        end
        prev_busy = bcd_busy;
    end

    // ---------------- driver tasks ----------------
    // Drives the pulse for one cycle. Returns at the negedge after the sampling edge.
    task automatic pulse(input logic up, input logic dn, input logic lu);
        @(negedge clk);
        btn_up_tick   = up;
        btn_down_tick = dn;
        level_up      = lu;
        @(negedge clk);
        btn_up_tick   = 1'b0;
        btn_down_tick = 1'b0;
        level_up      = 1'b0;
    endtask

    // Bounded wait for the converter to drain. Leftover expectations count as failures.
    task automatic settle();
        repeat (60) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_score"}, int'(score), 0);
        chk({tag, "_hiscore"}, int'(hiscore), 0);
        chk({tag, "_level"}, int'(level), 1);
        chk({tag, "_score_bcd"}, int'(score_bcd), 'h000);
        chk({tag, "_hiscore_bcd"}, int'(hiscore_bcd), 'h000);
        chk({tag, "_level_bcd"}, int'(level_bcd), 'h01);
        chk({tag, "_busy"}, int'(bcd_busy), 0);
    endtask

    // global time limit
    initial begin
        #500000;
        errors++;
        $display("FAIL timeout got no finish expected finish before limit");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1; state = 2'd0;
        btn_up_tick = 1'b0; btn_down_tick = 1'b0; level_up = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_values("reset");
        reset = 1'b0;
        state = 2'd1;
        @(negedge clk);
        mon_en = 1'b1;

        // 1: three up ticks -> 10, 20, 30. Hiscore follows each one.
        push(2'd0, 12'h010); push(2'd1, 12'h010);
        pulse(1, 0, 0); chk("up1_score", int'(score), 10);
        settle();
        push(2'd0, 12'h020); push(2'd1, 12'h020);
        pulse(1, 0, 0); chk("up2_score", int'(score), 20);
        settle();
        push(2'd0, 12'h030); push(2'd1, 12'h030);
        pulse(1, 0, 0); chk("up3_score", int'(score), 30);
        repeat (11) @(negedge clk);
        chk("score_bcd_before_12", int'(score_bcd), 'h020);
        @(negedge clk);
        chk("score_bcd_at_12", int'(score_bcd), 'h030);
        settle();
        chk("up3_hiscore", int'(hiscore), 30);
        chk("up3_hiscore_bcd", int'(hiscore_bcd), 'h030);

        // 2: from row 3 go down, then up twice. Only a row never reached before scores.
`ifdef SCORE_PENALTY_EN
        push(2'd0, 12'h020);
        pulse(0, 1, 0); chk("down_score", int'(score), 20);
        pulse(1, 0, 0); chk("reclimb_score", int'(score), 20);
        push(2'd0, 12'h030);
        pulse(1, 0, 0); chk("newrow_score", int'(score), 30);
        settle();
        chk("newrow_hiscore", int'(hiscore), 30);
`else
        pulse(0, 1, 0); chk("down_score", int'(score), 30);
        pulse(1, 0, 0); chk("reclimb_score", int'(score), 30);
        push(2'd0, 12'h040); push(2'd1, 12'h040);
        pulse(1, 0, 0); chk("newrow_score", int'(score), 40);
        settle();
        chk("newrow_hiscore", int'(hiscore), 40);
`endif

        // 3: an up and a down in the same cycle cancel out. Ticks are ignored in DEAD.
        //    Then climb until the top row saturates.
        pulse(1, 1, 0);
`ifdef SCORE_PENALTY_EN
        chk("updown_score", int'(score), 30);
`else
        chk("updown_score", int'(score), 40);
`endif
        state = 2'd2;
        pulse(1, 0, 0);
`ifdef SCORE_PENALTY_EN
        chk("dead_tick_score", int'(score), 30);
`else
        chk("dead_tick_score", int'(score), 40);
`endif
        state = 2'd1;
        settle();
        mon_en = 1'b0;
        repeat (20) pulse(1, 0, 0);
        settle();
        mon_en = 1'b1;
`ifdef SCORE_PENALTY_EN
        chk("top_score", int'(score), 130);
        chk("top_score_bcd", int'(score_bcd), 'h130);
        chk("top_hiscore_bcd", int'(hiscore_bcd), 'h130);
        pulse(1, 0, 0); chk("row_sat_score", int'(score), 130);
`else
        chk("top_score", int'(score), 140);
        chk("top_score_bcd", int'(score_bcd), 'h140);
        chk("top_hiscore_bcd", int'(hiscore_bcd), 'h140);
        pulse(1, 0, 0); chk("row_sat_score", int'(score), 140);
`endif
        settle();

        // 4: bring the score to 950 with level ups and rows. The next level_up saturates it at 999.
        mon_en = 1'b0;
        repeat (8) pulse(0, 0, 1);
`ifdef SCORE_PENALTY_EN
        repeat (2) pulse(1, 0, 0);
`else
        pulse(1, 0, 0);
`endif
        settle();
        mon_en = 1'b1;
        chk("pre_bonus_score", int'(score), 950);
        chk("pre_bonus_level", int'(level), 9);
        chk("pre_bonus_level_bcd", int'(level_bcd), 'h09);
        push(2'd0, 12'h999); push(2'd1, 12'h999); push(2'd2, 12'h010);
        pulse(0, 0, 1);
        chk("bonus_score_sat", int'(score), 999);
        chk("bonus_level", int'(level), 10);
        settle();
        pulse(1, 0, 0); chk("row_add_sat", int'(score), 999);
        settle();
        state = 2'd2;
        push(2'd2, 12'h011);
        pulse(0, 0, 1); chk("dead_level_up", int'(level), 11);
        settle();
        mon_en = 1'b0;
        repeat (95) pulse(0, 0, 1);
        settle();
        mon_en = 1'b1;
        chk("level_sat", int'(level), 99);
        chk("level_sat_bcd", int'(level_bcd), 'h99);
        chk("level_sat_score", int'(score), 999);

        // 5: MENU clears score and level. The high score is kept.
        push(2'd0, 12'h000); push(2'd2, 12'h001);
        @(negedge clk); state = 2'd0;
        @(negedge clk);
        chk("menu_score", int'(score), 0);
        chk("menu_level", int'(level), 1);
        chk("menu_hiscore", int'(hiscore), 999);
        settle();
        chk("menu_hiscore_bcd", int'(hiscore_bcd), 'h999);
        chk("menu_score_bcd", int'(score_bcd), 'h000);

        // 6: a down tick at score 0 does not wrap.
        state = 2'd1;
        pulse(0, 1, 0); chk("down_at_zero", int'(score), 0);
        settle();

        // Reset while the converter is in SHIFT.
        mon_en = 1'b0;
        pulse(1, 0, 0); chk("pre_reset_score", int'(score), 10);
        repeat (4) @(negedge clk);
        chk("mid_shift_busy", int'(bcd_busy), 1);
        #1 reset = 1'b1;
        #1;
        chk_reset_values("mid_reset");
        @(negedge clk);
        reset = 1'b0;
        state = 2'd0;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
